// File: rtl/prog_loader_pkg.sv
// Shared cpu/loader definitions: memory geometry defaults, frame marker and loader state type.
package prog_loader_pkg;

    localparam int LOADER_WORD_WIDTH = 16;
    localparam int LOADER_ADDR_WIDTH = 8;
    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Assembles bytes MSB-first into WORD_WIDTH words; word_valid_o fires combinationally
// with the last byte of each word so the caller can register the write.
module loader_word_asm #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  word_valid_o,
    output logic [WORD_WIDTH-1:0] word_o
);

    localparam int BPW   = WORD_WIDTH / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Older bytes fall off the top, so no per-word clear of the shifter is needed.
    assign word_o       = WORD_WIDTH'({shift_q, byte_i});
    assign word_valid_o = byte_valid_i && (cnt_q == CNT_W'(BPW - 1));

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = word_o;
            cnt_d   = word_valid_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC/LEN/data frames from a UART byte stream and writes
// words to cpu memory from address 0, holding the cpu in reset until a good image is in.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         WORD_WIDTH     = LOADER_WORD_WIDTH,
    parameter int         ADDR_WIDTH     = LOADER_ADDR_WIDTH,
    parameter logic [7:0] SYNC_BYTE      = LOADER_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e TAIL_STATE = ST_CSUM;
`else
    localparam loader_state_e TAIL_STATE = ST_DONE;
`endif

    loader_state_e         state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  start_frame;
    logic                  asm_byte_valid;
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] asm_word;
    logic                  to_active;
    logic [TO_W-1:0]       to_next;
    logic                  timeout;
    logic [15:0]           len_full;

    // SYNC only restarts from a resting state; inside a frame it is ordinary data.
    assign start_frame = in_valid && (in_data == SYNC_BYTE) &&
                         (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign asm_byte_valid = in_valid && (state_q == ST_DATA) && (word_cnt_q != len_q);
    assign len_full  = {len_hi_q, in_data};
    assign to_active = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign to_next   = to_cnt_q + 1'b1;
    assign timeout   = to_active && !in_valid && (to_next == TO_W'(TIMEOUT_CYCLES));

    loader_word_asm #(.WORD_WIDTH(WORD_WIDTH)) u_word_asm (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (start_frame),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (asm_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start_frame) state_d = ST_LEN_HI;
            ST_LEN_HI: if (in_valid) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (in_valid) begin
                    if (17'(len_full) > MAX_LEN) state_d = ST_ERR;
                    else if (len_full == 16'd0)  state_d = TAIL_STATE;
                    else                         state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            // Leave DATA on the last byte so a checksum byte on the very next cycle is caught.
            ST_DATA: if (word_valid && word_cnt_q == len_q - 16'd1) state_d = ST_CSUM;
            ST_CSUM: if (in_valid) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
`else
            ST_DATA: if (mem_we_q && word_cnt_q == len_q) state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_ERR;
    end

    // Status flags are registered from the next state so cpu_hold cannot glitch.
    always_comb begin
        cpu_hold_d  = (state_d != ST_DONE);
        load_done_d = (state_d == ST_DONE);
        load_err_d  = (state_d == ST_ERR);
    end

    always_comb begin
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        to_cnt_d    = (to_active && !in_valid) ? to_next : '0;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        if (in_valid && (state_q == ST_LEN_HI || state_q == ST_LEN_LO || asm_byte_valid))
            csum_d = csum_q + in_data;
`endif
        if (start_frame) begin
            len_hi_d   = '0;
            len_d      = '0;
            word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end
        if (in_valid && state_q == ST_LEN_HI) len_hi_d = in_data;
        if (in_valid && state_q == ST_LEN_LO) len_d = len_full;
        if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = asm_word;
            word_cnt_d  = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi_q    <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            to_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model checked every cycle, plus literal
// expectations per test frame. Follows LOADER_CHECKSUM_EN to append checksum bytes.
module tb_prog_loader;

    localparam int WW  = 16;
    localparam int AW  = 8;
    localparam int BPW = WW / 8;
    localparam int TO  = 50;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW+WW-1:0] wr_q[$];

    prog_loader #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: tracks byte position within the frame and derives
    // what the outputs must be after each clock edge.
    bit            m_in_frame = 0;
    bit            m_finish = 0;
    int            m_pos = 0, m_len = 0, m_len_hi = 0, m_sum = 0, m_idle = 0;
    logic [WW-1:0] m_buf = '0;
    logic [WW-1:0] m_nb;
    int            m_lenv;
    logic          exp_we = 0, exp_hold = 1, exp_done = 0, exp_err = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [WW-1:0] exp_wdata = '0;

    assign m_nb   = WW'({m_buf, in_data});
    assign m_lenv = m_len_hi * 256 + int'(in_data);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_frame <= 0; m_finish <= 0; m_pos <= 0; m_len <= 0; m_len_hi <= 0;
            m_sum <= 0; m_idle <= 0; m_buf <= '0;
            exp_we <= 0; exp_hold <= 1; exp_done <= 0; exp_err <= 0;
            exp_addr <= '0; exp_wdata <= '0;
        end else begin
            exp_we <= 1'b0;
            if (m_finish) begin
                m_finish <= 0; m_in_frame <= 0; exp_done <= 1; exp_hold <= 0;
            end else if (!m_in_frame) begin
                if (in_valid && in_data == 8'hA5) begin
                    m_in_frame <= 1; m_pos <= 0; m_sum <= 0; m_idle <= 0; m_buf <= '0;
                    exp_done <= 0; exp_err <= 0; exp_hold <= 1;
                end
            end else if (!in_valid) begin
                m_idle <= m_idle + 1;
                if (m_idle + 1 == TO) begin
                    m_in_frame <= 0; exp_err <= 1;
                end
            end else begin
                m_idle <= 0;
                m_pos  <= m_pos + 1;
                if (m_pos == 0) begin
                    m_len_hi <= int'(in_data);
                    m_sum    <= m_sum + int'(in_data);
                end else if (m_pos == 1) begin
                    m_len <= m_lenv;
                    m_sum <= m_sum + int'(in_data);
                    if (m_lenv > 2 ** AW) begin
                        m_in_frame <= 0; exp_err <= 1;
                    end
`ifndef LOADER_CHECKSUM_EN
                    else if (m_lenv == 0) begin
                        m_in_frame <= 0; exp_done <= 1; exp_hold <= 0;
                    end
`endif
                end else if (m_pos - 2 < m_len * BPW) begin
                    m_buf <= m_nb;
                    m_sum <= m_sum + int'(in_data);
                    if ((m_pos - 2) % BPW == BPW - 1) begin
                        exp_we    <= 1'b1;
                        exp_addr  <= AW'((m_pos - 2) / BPW);
                        exp_wdata <= m_nb;
`ifndef LOADER_CHECKSUM_EN
                        if ((m_pos - 2) / BPW == m_len - 1) m_finish <= 1;
`endif
                    end
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    m_in_frame <= 0;
                    if (in_data == 8'(m_sum)) begin
                        exp_done <= 1; exp_hold <= 0;
                    end else begin
                        exp_err <= 1;
                    end
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the model; also logs writes for literal checks.
    always @(negedge clk) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        check("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
        check("load_done", 32'(load_done), 32'(exp_done));
        check("load_err", 32'(load_err), 32'(exp_err));
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input bq_t f, input int gap);
        foreach (f[i]) begin
            send(f[i]);
            if (gap > 0) idle(gap);
        end
        idle(4);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"}, 32'(load_err), 32'(err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
    endtask

    initial begin
        bq_t f;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        #1 rst = 1'b0;
        #1;
        check("rst_we", 32'(mem_we), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset asserted mid-frame, while the first word's write strobe is high.
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (f[i]) send(f[i]);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        check("pre_rst_wdata", 32'(mem_wdata), 32'h1234);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_q.delete();
        f = '{8'hAB, 8'hCD, 8'h12, 8'h34};
        send_frame(f, 0);
        check("post_rst_writes", 32'(wr_q.size()), 32'd0);

        // Two-word frame with one idle cycle between bytes.
        wr_q.delete();
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'hC0);
`endif
        send_frame(f, 1);
        check("a_writes", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("a_w0", 32'(wr_q[0]), 32'h00_1234);
            check("a_w1", 32'(wr_q[1]), 32'h01_ABCD);
        end
        check_status("a", 1'b1, 1'b0, 1'b0);

        // Zero-length frame.
        wr_q.delete();
        f = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        send_frame(f, 0);
        check("zero_writes", 32'(wr_q.size()), 32'd0);
        check_status("zero", 1'b1, 1'b0, 1'b0);

        // Length 257 exceeds the 256-word capacity.
        wr_q.delete();
        f = '{8'hA5, 8'h01, 8'h01};
        send_frame(f, 0);
        check("big_writes", 32'(wr_q.size()), 32'd0);
        check_status("big", 1'b0, 1'b1, 1'b1);

        // Exactly full capacity, back-to-back bytes; word i = {i, ~i}.
        wr_q.delete();
        begin
            logic [7:0] s;
            f = '{8'hA5, 8'h01, 8'h00};
            s = 8'h01;
            for (int i = 0; i < 256; i++) begin
                f.push_back(8'(i));
                f.push_back(~8'(i));
                s = s + 8'(i) + ~8'(i);
            end
`ifdef LOADER_CHECKSUM_EN
            f.push_back(s);
`endif
        end
        send_frame(f, 0);
        check("full_writes", 32'(wr_q.size()), 32'd256);
        if (wr_q.size() == 256) begin
            check("full_first", 32'(wr_q[0]), 32'h00_00FF);
            check("full_last", 32'(wr_q[255]), 32'hFF_FF00);
        end
        check_status("full", 1'b1, 1'b0, 1'b0);

        // One-word frame; with the checksum build the trailing 09 is wrong (08 expected).
        wr_q.delete();
        f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h09);
`endif
        send_frame(f, 1);
        check("one_writes", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("one_w0", 32'(wr_q[0]), 32'h00_0007);
`ifdef LOADER_CHECKSUM_EN
        check_status("one", 1'b0, 1'b1, 1'b1);
`else
        check_status("one", 1'b1, 1'b0, 1'b0);
`endif

        // Stall mid-word: error exactly after TO idle cycles.
        wr_q.delete();
        f = '{8'hA5, 8'h00, 8'h01, 8'h00};
        foreach (f[i]) send(f[i]);
        idle(TO);
        check("to_early_err", 32'(load_err), 32'd0);
        idle(1);
        check("to_err", 32'(load_err), 32'd1);
        check("to_hold", 32'(cpu_hold), 32'd1);
        idle(3);
        f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h06);
`endif
        send_frame(f, 0);
        check("rec_writes", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("rec_w0", 32'(wr_q[0]), 32'h00_0005);
        check_status("rec", 1'b1, 1'b0, 1'b0);

        // SYNC value inside the data is plain data.
        wr_q.delete();
        f = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h4B);
`endif
        send_frame(f, 0);
        check("sync_writes", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("sync_w0", 32'(wr_q[0]), 32'h00_A5A5);
        check_status("sync", 1'b1, 1'b0, 1'b0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
